// File: rtl/wb_unified_mem_arbiter_pkg.sv
// Shared codes for the unified code/data memory arbiter.
// State and grant encodings are visible to both RTL and status logic.
package wb_unified_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'b00,
      ARB_GNT_I = 2'b01,
      ARB_GNT_D = 2'b10
   } arb_state_e;

   typedef enum logic {
      LAST_IBUS = 1'b0,
      LAST_DBUS = 1'b1
   } master_e;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_IBUS = 2'b01;
   localparam logic [1:0] GRANT_DBUS = 2'b10;

endpackage

// File: rtl/wb_unified_mem_arbiter.sv
// Two-master to one-slave classic Wishbone arbiter, one transfer per
// grant, with a watchdog that errors cycles the memory never finishes.
module wb_unified_mem_arbiter
   import wb_unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int DBUS_PRIORITY  = 1,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   iwb_adr_i,
   input  logic                    iwb_cyc_i,
   input  logic                    iwb_stb_i,
   output logic [DATA_WIDTH-1:0]   iwb_dat_o,
   output logic                    iwb_ack_o,
   output logic                    iwb_err_o,
   input  logic [ADDR_WIDTH-1:0]   dwb_adr_i,
   input  logic [DATA_WIDTH-1:0]   dwb_dat_i,
   input  logic                    dwb_we_i,
   input  logic [DATA_WIDTH/8-1:0] dwb_sel_i,
   input  logic                    dwb_cyc_i,
   input  logic                    dwb_stb_i,
   output logic [DATA_WIDTH-1:0]   dwb_dat_o,
   output logic                    dwb_ack_o,
   output logic                    dwb_err_o,
   output logic [ADDR_WIDTH-1:0]   s_adr_o,
   output logic [DATA_WIDTH-1:0]   s_dat_o,
   output logic                    s_we_o,
   output logic [DATA_WIDTH/8-1:0] s_sel_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   input  logic [DATA_WIDTH-1:0]   s_dat_i,
   input  logic                    s_ack_i,
   input  logic                    s_err_i,
   output logic [1:0]              grant_o
);

   localparam int WDW = $clog2(TIMEOUT_CYCLES);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

   arb_state_e     state_q, state_d;
   master_e        last_q, last_d;
   logic [WDW-1:0] wdog_q, wdog_d;
   logic           req_i, req_d;

   assign req_i = iwb_cyc_i & iwb_stb_i;
   assign req_d = dwb_cyc_i & dwb_stb_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         last_q  <= LAST_IBUS;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      wdog_d    = wdog_q;
      grant_o   = GRANT_NONE;
      s_adr_o   = '0;
      s_dat_o   = '0;
      s_we_o    = 1'b0;
      s_sel_o   = '0;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      iwb_dat_o = '0;
      iwb_ack_o = 1'b0;
      iwb_err_o = 1'b0;
      dwb_dat_o = '0;
      dwb_ack_o = 1'b0;
      dwb_err_o = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            wdog_d = '0;
            if (req_i && req_d) begin
               if (DBUS_PRIORITY != 0 || last_q == LAST_IBUS)
                  state_d = ARB_GNT_D;
               else
                  state_d = ARB_GNT_I;
            end else if (req_d) begin
               state_d = ARB_GNT_D;
            end else if (req_i) begin
               state_d = ARB_GNT_I;
            end
         end
         ARB_GNT_I: begin
            grant_o = GRANT_IBUS;
            s_adr_o = iwb_adr_i;
            s_sel_o = '1;
            s_cyc_o = req_i;
            s_stb_o = req_i;
            // a dropped request aborts silently and keeps fairness history
            if (!req_i) begin
               state_d = ARB_IDLE;
            end else if (s_err_i) begin
               iwb_err_o = 1'b1;
               state_d   = ARB_IDLE;
               last_d    = LAST_IBUS;
            end else if (s_ack_i) begin
               iwb_ack_o = 1'b1;
               iwb_dat_o = s_dat_i;
               state_d   = ARB_IDLE;
               last_d    = LAST_IBUS;
            end else if (wdog_q == WD_LAST) begin
               iwb_err_o = 1'b1;
               s_cyc_o   = 1'b0;
               s_stb_o   = 1'b0;
               state_d   = ARB_IDLE;
               last_d    = LAST_IBUS;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         ARB_GNT_D: begin
            grant_o = GRANT_DBUS;
            s_adr_o = dwb_adr_i;
            s_dat_o = dwb_dat_i;
            s_we_o  = dwb_we_i;
            s_sel_o = dwb_sel_i;
            s_cyc_o = req_d;
            s_stb_o = req_d;
            if (!req_d) begin
               state_d = ARB_IDLE;
            end else if (s_err_i) begin
               dwb_err_o = 1'b1;
               state_d   = ARB_IDLE;
               last_d    = LAST_DBUS;
            end else if (s_ack_i) begin
               dwb_ack_o = 1'b1;
               dwb_dat_o = s_dat_i;
               state_d   = ARB_IDLE;
               last_d    = LAST_DBUS;
            end else if (wdog_q == WD_LAST) begin
               dwb_err_o = 1'b1;
               s_cyc_o   = 1'b0;
               s_stb_o   = 1'b0;
               state_d   = ARB_IDLE;
               last_d    = LAST_DBUS;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Directed bench: u0 is dbus-priority with a 16-cycle watchdog,
// u1 is round-robin; each has its own registered-ack memory.
module tb_wb_unified_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] i_adr, d_adr, d_dat;
   logic        i_cyc, i_stb, d_we, d_cyc, d_stb;
   logic [3:0]  d_sel;
   logic [31:0] iwb_dat, dwb_dat;
   logic        iwb_ack, iwb_err, dwb_ack, dwb_err;
   logic [31:0] s_adr, s_dat_o, s_dat_i;
   logic        s_we, s_cyc, s_stb, s_ack, s_err;
   logic [3:0]  s_sel;
   logic [1:0]  grant;

   logic        noack = 1'b0;
   logic        err_mode = 1'b0;
   logic [31:0] mem [0:2047];

   wb_unified_mem_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .DBUS_PRIORITY(1), .TIMEOUT_CYCLES(16)
   ) u0 (
      .clk(clk), .rst_n(rst_n),
      .iwb_adr_i(i_adr), .iwb_cyc_i(i_cyc), .iwb_stb_i(i_stb),
      .iwb_dat_o(iwb_dat), .iwb_ack_o(iwb_ack), .iwb_err_o(iwb_err),
      .dwb_adr_i(d_adr), .dwb_dat_i(d_dat), .dwb_we_i(d_we),
      .dwb_sel_i(d_sel), .dwb_cyc_i(d_cyc), .dwb_stb_i(d_stb),
      .dwb_dat_o(dwb_dat), .dwb_ack_o(dwb_ack), .dwb_err_o(dwb_err),
      .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_we_o(s_we),
      .s_sel_o(s_sel), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
      .grant_o(grant)
   );

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ack   <= 1'b0;
         s_dat_i <= '0;
      end else begin
         s_ack <= s_cyc & s_stb & !s_ack & !noack;
         if (s_cyc && s_stb && !s_ack && !noack) begin
            if (s_we)
               mem[s_adr[12:2]] <= merge(mem[s_adr[12:2]], s_dat_o, s_sel);
            else
               s_dat_i <= mem[s_adr[12:2]];
         end
      end
   end
   assign s_err = s_ack & err_mode;

   logic [31:0] r_adr;
   logic        r_i_req, r_d_req;
   logic [31:0] r_iwb_dat, r_dwb_dat, r_s_adr, r_s_dat_o;
   logic        r_iwb_ack, r_iwb_err, r_dwb_ack, r_dwb_err;
   logic        r_s_we, r_s_cyc, r_s_stb, r_s_ack;
   logic [3:0]  r_s_sel;
   logic [1:0]  r_grant;

   wb_unified_mem_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .DBUS_PRIORITY(0), .TIMEOUT_CYCLES(16)
   ) u1 (
      .clk(clk), .rst_n(rst_n),
      .iwb_adr_i(r_adr), .iwb_cyc_i(r_i_req), .iwb_stb_i(r_i_req),
      .iwb_dat_o(r_iwb_dat), .iwb_ack_o(r_iwb_ack), .iwb_err_o(r_iwb_err),
      .dwb_adr_i(r_adr), .dwb_dat_i(32'h0), .dwb_we_i(1'b0),
      .dwb_sel_i(4'hF), .dwb_cyc_i(r_d_req), .dwb_stb_i(r_d_req),
      .dwb_dat_o(r_dwb_dat), .dwb_ack_o(r_dwb_ack), .dwb_err_o(r_dwb_err),
      .s_adr_o(r_s_adr), .s_dat_o(r_s_dat_o), .s_we_o(r_s_we),
      .s_sel_o(r_s_sel), .s_cyc_o(r_s_cyc), .s_stb_o(r_s_stb),
      .s_dat_i(32'h0), .s_ack_i(r_s_ack), .s_err_i(1'b0),
      .grant_o(r_grant)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_s_ack <= 1'b0;
      else        r_s_ack <= r_s_cyc & r_s_stb & !r_s_ack;
   end

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (grant !== 2'b00) begin
         errors++; $display("FAIL reset_grant: got %b want 00", grant);
      end
      checks++;
      if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o} !== '0) begin
         errors++; $display("FAIL reset_slave: got cyc=%b adr=%h want all 0", s_cyc, s_adr);
      end
      checks++;
      if ({iwb_ack, iwb_err, dwb_ack, dwb_err, iwb_dat, dwb_dat} !== '0) begin
         errors++; $display("FAIL reset_master: got nonzero want all 0");
      end
      checks++;
      if (r_grant !== 2'b00 || r_s_cyc !== 1'b0) begin
         errors++; $display("FAIL reset_u1: got grant=%b cyc=%b want 00/0", r_grant, r_s_cyc);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_ibus_read();
      int lat = 0;
      logic [31:0] dat = '0;
      @(negedge clk);
      i_adr = 32'h100; i_cyc = 1'b1; i_stb = 1'b1;
      d_dat = 32'hDEADBEEF;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         @(negedge clk);
         checks++;
         if (dwb_ack !== 1'b0) begin
            errors++; $display("FAIL ird_dack: got %b want 0", dwb_ack);
         end
         checks++;
         if (grant !== 2'b01) begin
            errors++; $display("FAIL ird_grant: got %b want 01 at c=%0d", grant, c);
         end
         if (iwb_ack === 1'b1) begin
            lat = c; dat = iwb_dat;
         end else if (c == 1) begin
            checks++;
            if (s_sel !== 4'hF || s_we !== 1'b0 || s_dat_o !== 32'h0 ||
                s_adr !== 32'h100 || s_stb !== 1'b1) begin
               errors++;
               $display("FAIL ird_mux: got sel=%h we=%b dat=%h adr=%h want F/0/0/100",
                        s_sel, s_we, s_dat_o, s_adr);
            end
         end
      end
      i_cyc = 1'b0; i_stb = 1'b0;
      checks++;
      if (lat != 2) begin
         errors++; $display("FAIL ird_latency: got %0d want 2", lat);
      end
      checks++;
      if (dat !== 32'h0000_0013) begin
         errors++; $display("FAIL ird_data: got %h want 00000013", dat);
      end
      @(negedge clk);
      checks++;
      if (grant !== 2'b00) begin
         errors++; $display("FAIL ird_idle: got %b want 00", grant);
      end
   endtask

   task automatic test_priority();
      int d_at = 0;
      int i_at = 0;
      logic [31:0] idat = '0;
      @(negedge clk);
      i_adr = 32'h0; i_cyc = 1'b1; i_stb = 1'b1;
      d_adr = 32'h1000; d_dat = 32'h1; d_we = 1'b1; d_sel = 4'hF;
      d_cyc = 1'b1; d_stb = 1'b1;
      for (int c = 1; c <= 20 && (d_at == 0 || i_at == 0); c++) begin
         @(negedge clk);
         if (c == 1) begin
            checks++;
            if (grant !== 2'b10) begin
               errors++; $display("FAIL pri_first: got %b want 10", grant);
            end
         end
         checks++;
         if ((iwb_ack && dwb_ack) || grant === 2'b11) begin
            errors++; $display("FAIL pri_overlap: got grant=%b want no overlap", grant);
         end
         if (dwb_ack === 1'b1) begin
            d_at = c; d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
         end
         if (iwb_ack === 1'b1) begin
            i_at = c; idat = iwb_dat; i_cyc = 1'b0; i_stb = 1'b0;
         end
      end
      checks++;
      if (d_at != 2 || i_at != 5) begin
         errors++; $display("FAIL pri_order: got d=%0d i=%0d want d=2 i=5", d_at, i_at);
      end
      checks++;
      if (mem[1024] !== 32'h1) begin
         errors++; $display("FAIL pri_write: got %h want 00000001", mem[1024]);
      end
      checks++;
      if (idat !== 32'h0A5A_5A5A) begin
         errors++; $display("FAIL pri_iread: got %h want 0a5a5a5a", idat);
      end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int n = 0;
      int nd = 0;
      int ni = 0;
      logic is_d [8];
      @(negedge clk);
      r_adr = 32'h40; r_i_req = 1'b1; r_d_req = 1'b1;
      for (int c = 1; c <= 60 && n < 8; c++) begin
         @(negedge clk);
         if (r_dwb_ack === 1'b1) begin
            is_d[n] = 1'b1; n++; nd++;
         end else if (r_iwb_ack === 1'b1) begin
            is_d[n] = 1'b0; n++; ni++;
         end
      end
      r_i_req = 1'b0; r_d_req = 1'b0;
      checks++;
      if (n != 8) begin
         errors++; $display("FAIL rr_count: got %0d acks want 8", n);
      end
      for (int k = 0; k < n; k++) begin
         checks++;
         if (is_d[k] !== ((k % 2) == 0)) begin
            errors++; $display("FAIL rr_order: got is_d=%b want %b at ack %0d",
                               is_d[k], (k % 2) == 0, k);
         end
      end
      checks++;
      if (nd != 4 || ni != 4) begin
         errors++; $display("FAIL rr_split: got d=%0d i=%0d want 4/4", nd, ni);
      end
      @(negedge clk);
   endtask

   task automatic test_watchdog();
      int err_at = -1;
      logic cyc_at_err = 1'b1;
      noack = 1'b1;
      @(negedge clk);
      d_adr = 32'h2000; d_we = 1'b0; d_cyc = 1'b1; d_stb = 1'b1;
      @(negedge clk);
      checks++;
      if (grant !== 2'b10 || dwb_err !== 1'b0) begin
         errors++; $display("FAIL wd_grant: got %b err=%b want 10/0", grant, dwb_err);
      end
      for (int c = 1; c <= 20 && err_at < 0; c++) begin
         @(negedge clk);
         if (dwb_err === 1'b1) begin
            err_at = c; cyc_at_err = s_cyc;
         end
      end
      checks++;
      if (err_at != 15) begin
         errors++; $display("FAIL wd_delay: got %0d want 15", err_at);
      end
      checks++;
      if (cyc_at_err !== 1'b0) begin
         errors++; $display("FAIL wd_cyc: got %b want 0", cyc_at_err);
      end
      @(negedge clk);
      checks++;
      if (grant !== 2'b00 || dwb_err !== 1'b0) begin
         errors++; $display("FAIL wd_idle: got %b err=%b want 00/0", grant, dwb_err);
      end
      d_cyc = 1'b0; d_stb = 1'b0; noack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_err();
      int at = 0;
      logic ack_at = 1'b1;
      err_mode = 1'b1;
      @(negedge clk);
      i_adr = 32'h100; i_cyc = 1'b1; i_stb = 1'b1;
      for (int c = 1; c <= 10 && at == 0; c++) begin
         @(negedge clk);
         if (iwb_err === 1'b1) begin
            at = c; ack_at = iwb_ack;
         end
      end
      i_cyc = 1'b0; i_stb = 1'b0;
      checks++;
      if (at != 2) begin
         errors++; $display("FAIL err_delay: got %0d want 2", at);
      end
      checks++;
      if (ack_at !== 1'b0) begin
         errors++; $display("FAIL err_ack: got %b want 0", ack_at);
      end
      @(negedge clk);
      err_mode = 1'b0;
   endtask

   task automatic test_abort();
      noack = 1'b1;
      @(negedge clk);
      d_adr = 32'h1000; d_we = 1'b0; d_cyc = 1'b1; d_stb = 1'b1;
      @(negedge clk);
      checks++;
      if (grant !== 2'b10 || s_cyc !== 1'b1) begin
         errors++; $display("FAIL abort_grant: got %b cyc=%b want 10/1", grant, s_cyc);
      end
      d_cyc = 1'b0; d_stb = 1'b0;
      #1;
      checks++;
      if (s_cyc !== 1'b0 || dwb_ack !== 1'b0 || dwb_err !== 1'b0) begin
         errors++;
         $display("FAIL abort_drop: got cyc=%b ack=%b err=%b want 0/0/0",
                  s_cyc, dwb_ack, dwb_err);
      end
      @(negedge clk);
      checks++;
      if (grant !== 2'b00) begin
         errors++; $display("FAIL abort_idle: got %b want 00", grant);
      end
      noack = 1'b0;
   endtask

   task automatic test_reset_mid();
      noack = 1'b1;
      @(negedge clk);
      i_adr = 32'h100; i_cyc = 1'b1; i_stb = 1'b1;
      @(negedge clk);
      checks++;
      if (grant !== 2'b01 || s_cyc !== 1'b1) begin
         errors++; $display("FAIL rstmid_grant: got %b cyc=%b want 01/1", grant, s_cyc);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({s_cyc, s_stb, s_adr, s_sel, grant, iwb_ack, iwb_err} !== '0) begin
         errors++; $display("FAIL rstmid_outs: got cyc=%b grant=%b adr=%h want 0",
                            s_cyc, grant, s_adr);
      end
      i_cyc = 1'b0; i_stb = 1'b0; noack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      i_adr = '0; i_cyc = 1'b0; i_stb = 1'b0;
      d_adr = '0; d_dat = '0; d_we = 1'b0; d_sel = 4'hF;
      d_cyc = 1'b0; d_stb = 1'b0;
      r_adr = '0; r_i_req = 1'b0; r_d_req = 1'b0;
      for (int k = 0; k < 2048; k++) mem[k] = '0;
      mem[0]  = 32'h0A5A_5A5A;
      mem[64] = 32'h0000_0013;
      test_reset();
      test_ibus_read();
      test_priority();
      test_round_robin();
      test_watchdog();
      test_err();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
